// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller: FSM state encoding and the
// RAM geometry defaults used by fifo_ctrl, memoria and the benches.
package fifo_ctrl_pkg;

    localparam int RAM_WIDTH_DEF = 10;
    localparam int RAM_DEPTH_DEF = 8;
    localparam int ADDR_SIZE_DEF = 3;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/fifo_flags.sv
// Combinational flag decode from the occupancy count and latched thresholds.
// Ports:
//   count                 occupancy, ADDR_SIZE+1 bits
//   af_th / ae_th         latched almost-full / almost-empty thresholds
//   full / empty          count == RAM_DEPTH / count == 0
//   almost_full           count >= af_th (never while empty)
//   almost_empty          count <= ae_th
module fifo_flags
    import fifo_ctrl_pkg::*;
#(
    parameter int RAM_DEPTH = RAM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic [ADDR_SIZE:0] count,
    input  logic [ADDR_SIZE:0] af_th,
    input  logic [ADDR_SIZE:0] ae_th,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty
);

    always_comb begin
        full         = (count == (ADDR_SIZE+1)'(RAM_DEPTH));
        empty        = (count == '0);
        // Thresholds reset to 0; an empty FIFO is never reported as almost
        // full, which keeps almost_full low out of reset.
        almost_full  = !empty && (count >= af_th);
        almost_empty = (count <= ae_th);
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage in front of the memoria RAM. Converts push/pop into
// memory write/read enables and addresses, forwards read data with a valid
// strobe, keeps the occupancy count and status flags, detects over/underflow.
// Ports:
//   clk, rst (async, active-low), init (flush + latch thresholds)
//   almost_full_th / almost_empty_th   thresholds, latched in INIT
//   push, push_data, pop               request handshake
//   pop_data, pop_valid                read data (registered RAM, 1-cycle)
//   mem_*                              memoria write/read port
//   full, empty, almost_full, almost_empty, error (sticky)
//   fifo_count                         occupancy, only with FIFO_COUNT_EN
// Optional feature macro: FIFO_COUNT_EN
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH = RAM_WIDTH_DEF,
    parameter int RAM_DEPTH = RAM_DEPTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic [ADDR_SIZE:0]   almost_full_th,
    input  logic [ADDR_SIZE:0]   almost_empty_th,
    input  logic                 push,
    input  logic [RAM_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [RAM_WIDTH-1:0] pop_data,
    output logic                 pop_valid,
    output logic [RAM_WIDTH-1:0] mem_data_in,
    output logic                 mem_wr_enb,
    output logic [ADDR_SIZE-1:0] mem_wr_addr,
    output logic                 mem_rd_enb,
    output logic [ADDR_SIZE-1:0] mem_rd_addr,
    input  logic [RAM_WIDTH-1:0] mem_data_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error
`ifdef FIFO_COUNT_EN
    ,
    output logic [ADDR_SIZE:0]   fifo_count
`endif
);

    state_t               state, state_nxt;
    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
    logic [ADDR_SIZE:0]   count, af_th, ae_th;
    logic                 running, push_ok, pop_ok, overflow, underflow;

    // Requests are only honoured in IDLE/ACTIVE, and init overrides them.
    always_comb begin
        running   = ((state == ST_IDLE) || (state == ST_ACTIVE)) && !init;
        underflow = running && pop && empty;
        overflow  = running && push && full && !pop;
        pop_ok    = running && pop && !empty;
        // An underflowing cycle accepts neither side.
        push_ok   = running && push && !underflow && (!full || pop_ok);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RESET: state_nxt = ST_INIT;
            ST_INIT:  if (!init) state_nxt = ST_IDLE;
            ST_IDLE, ST_ACTIVE: begin
                if (init)
                    state_nxt = ST_INIT;
                else if (overflow || underflow)
                    state_nxt = ST_ERROR;
                else if (state == ST_IDLE && push_ok)
                    state_nxt = ST_ACTIVE;
                else if (state == ST_ACTIVE && pop_ok && !push_ok && count == 1)
                    state_nxt = ST_IDLE;
            end
            ST_ERROR: if (init) state_nxt = ST_INIT;
            default:  state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RESET;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            af_th     <= '0;
            ae_th     <= '0;
            pop_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pop_valid <= pop_ok;
            if (state == ST_INIT) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                af_th  <= almost_full_th;
                ae_th  <= almost_empty_th;
                error  <= 1'b0;
            end else begin
                // Depth is a power of two, so pointers wrap naturally.
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
                if (push_ok && !pop_ok)      count <= count + 1'b1;
                else if (pop_ok && !push_ok) count <= count - 1'b1;
                if (overflow || underflow) error <= 1'b1;
            end
        end
    end

    assign mem_data_in = push_data;
    assign mem_wr_enb  = push_ok;
    assign mem_wr_addr = wr_ptr;
    assign mem_rd_enb  = pop_ok;
    assign mem_rd_addr = rd_ptr;
    assign pop_data    = mem_data_out;

`ifdef FIFO_COUNT_EN
    assign fifo_count = count;
`endif

    fifo_flags #(
        .RAM_DEPTH (RAM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_flags (
        .count        (count),
        .af_th        (af_th),
        .ae_th        (ae_th),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios plus randomized push/pop/init,
// checked every cycle against a queue-based model of the FIFO.
module tb_fifo_ctrl;

    localparam int W = 10;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    localparam int M_RST  = 0;
    localparam int M_INIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_ERR  = 3;

    logic          clk = 1'b0;
    logic          rst, init, push, pop;
    logic [AW:0]   af_in, ae_in;
    logic [W-1:0]  push_data, pop_data, mem_data_in, mem_data_out;
    logic          pop_valid, mem_wr_enb, mem_rd_enb;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic          full, empty, almost_full, almost_empty, error;
`ifdef FIFO_COUNT_EN
    logic [AW:0]   fifo_count;
`endif

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [W-1:0] q[$];
    int           mode = M_RST;
    int           m_af = 0, m_ae = 0;
    bit           m_err = 0;
    bit           exp_pv = 0;
    logic [W-1:0] exp_pd = '0;
    int           wc = 0, rc = 0;

    // memoria stand-in: registered read, read-before-write
    logic [W-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_enb) mem[mem_wr_addr] <= mem_data_in;
        if (mem_rd_enb) mem_data_out <= mem[mem_rd_addr];
    end

    fifo_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .ADDR_SIZE(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .init            (init),
        .almost_full_th  (af_in),
        .almost_empty_th (ae_in),
        .push            (push),
        .push_data       (push_data),
        .pop             (pop),
        .pop_data        (pop_data),
        .pop_valid       (pop_valid),
        .mem_data_in     (mem_data_in),
        .mem_wr_enb      (mem_wr_enb),
        .mem_wr_addr     (mem_wr_addr),
        .mem_rd_enb      (mem_rd_enb),
        .mem_rd_addr     (mem_rd_addr),
        .mem_data_out    (mem_data_out),
        .full            (full),
        .empty           (empty),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .error           (error)
`ifdef FIFO_COUNT_EN
        ,
        .fifo_count      (fifo_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pop_valid"}, pop_valid, 0);
        chk({tag, ".error"}, error, 0);
        chk({tag, ".empty"}, empty, 1);
        chk({tag, ".full"}, full, 0);
        chk({tag, ".almost_full"}, almost_full, 0);
        chk({tag, ".almost_empty"}, almost_empty, 1);
        chk({tag, ".wr_enb"}, mem_wr_enb, 0);
        chk({tag, ".rd_enb"}, mem_rd_enb, 0);
    endtask

    task automatic model_reset();
        q.delete();
        mode = M_RST; m_af = 0; m_ae = 0; m_err = 0;
        exp_pv = 0; wc = 0; rc = 0;
    endtask

    // One clock cycle: drive, check mid-cycle, advance model, cross the edge.
    task automatic step(input bit ph, input logic [W-1:0] pd, input bit pp, input bit in);
        int n;
        bit ew, er, ovf, udf;
        push = ph; push_data = pd; pop = pp; init = in;
        #3;
        n = q.size();
        ew = 0; er = 0; ovf = 0; udf = 0;
        if (mode == M_RUN && !in) begin
            udf = pp && (n == 0);
            ovf = ph && !pp && (n == DEPTH);
            if (!udf && !ovf) begin
                er = pp && (n > 0);
                ew = ph && ((n < DEPTH) || er);
            end
        end
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("almost_full", almost_full, (n != 0) && (n >= m_af));
        chk("almost_empty", almost_empty, n <= m_ae);
        chk("error", error, m_err);
        chk("wr_enb", mem_wr_enb, ew);
        chk("rd_enb", mem_rd_enb, er);
        if (ew) begin
            chk("wr_addr", mem_wr_addr, wc % DEPTH);
            chk("data_in", mem_data_in, pd);
        end
        if (er) chk("rd_addr", mem_rd_addr, rc % DEPTH);
        chk("pop_valid", pop_valid, exp_pv);
        if (exp_pv) chk("pop_data", pop_data, exp_pd);
`ifdef FIFO_COUNT_EN
        chk("fifo_count", fifo_count, n);
`endif
        exp_pv = er;
        if (er) begin exp_pd = q.pop_front(); rc++; end
        if (ew) begin q.push_back(pd); wc++; end
        case (mode)
            M_RST:  mode = M_INIT;
            M_INIT: begin
                q.delete(); wc = 0; rc = 0; m_err = 0;
                m_af = int'(af_in); m_ae = int'(ae_in);
                if (!in) mode = M_RUN;
            end
            M_RUN: begin
                if (in) mode = M_INIT;
                else if (udf || ovf) begin m_err = 1; mode = M_ERR; end
            end
            default: if (in) mode = M_INIT;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input int af, input int ae);
        af_in = (AW+1)'(af); ae_in = (AW+1)'(ae);
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; init = 1'b1; push = 0; pop = 0; push_data = '0;
        af_in = 4'd6; ae_in = 4'd2;
        #1;
        chk_reset_vals("por");
        @(posedge clk); #1;
        rst = 1'b1;

        // bring-up: RESET -> INIT -> IDLE
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);

        // fill with 3A1..3A8, then drain in order
        for (int i = 1; i <= 8; i++) step(1, W'(10'h3A0 + i), 0, 0);
        chk("filled.full", full, 1);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        chk("drained.empty", empty, 1);

        // second fill wraps wr_ptr; full push+pop; then overflow
        for (int i = 0; i < 8; i++) step(1, W'(10'h200 + i), 0, 0);
        step(1, 10'h155, 1, 0);
        step(0, '0, 0, 0);
        step(1, 10'h0AA, 0, 0);
        step(0, '0, 0, 0);
        chk("ovf.error", error, 1);
        chk("ovf.full", full, 1);
        do_init(6, 2);
        step(0, '0, 0, 0);
        chk("reinit.error", error, 0);
        chk("reinit.empty", empty, 1);

        // underflow with simultaneous push
        step(1, 10'h111, 1, 0);
        step(0, '0, 0, 0);
        chk("udf.error", error, 1);
        do_init(6, 2);

        // full push+pop then drain: 155 must come out last
        for (int i = 0; i < 8; i++) step(1, W'(10'h300 + i), 0, 0);
        step(1, 10'h155, 1, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // randomized traffic with occasional re-init and threshold changes
        for (int c = 0; c < 600; c++) begin
            int n;
            n = q.size();
            if ($urandom_range(0, 49) == 0 || (mode == M_ERR && $urandom_range(0, 3) == 0)) begin
                af_in = (AW+1)'($urandom_range(0, 10));
                ae_in = (AW+1)'($urandom_range(0, 8));
                step(0, '0, 0, 1);
            end else begin
                step($urandom_range(0, 99) < ((n == DEPTH) ? 15 : 55),
                     W'($urandom),
                     $urandom_range(0, 99) < ((n == 0) ? 5 : 45),
                     0);
            end
        end

        // reset asserted between edges while a pop result is in flight
        do_init(6, 2);
        for (int i = 0; i < 4; i++) step(1, W'(10'h0F0 + i), 0, 0);
        step(0, '0, 1, 0);
        push = 1; pop = 1; push_data = 10'h3FF; init = 0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        @(posedge clk); #1;
        chk("midrst.hold_pv", pop_valid, 0);
        chk("midrst.hold_empty", empty, 1);
        rst = 1'b1;
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, W'(10'h050 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
